pma_scan_ctrl: RTL and testbench

- Iterative physical-memory-attribute lookup controller.
- Takes one physical address per request and walks the core-config rule tables (non-idempotent, execute, cacheable) at RulesPerCycle rules per cycle.
- Returns three attribute flags through a valid/ready response.
- Sits beside the LSU/PTW as an area-reduced alternative to a fully parallel 3×16-comparator PMA check.

---
 rtl/config_pkg.sv | 51 +++++
 rtl/pma_scan_ctrl_pkg.sv | 20 ++
 rtl/pma_scan_slice.sv | 15 +
 rtl/pma_scan_ctrl.sv | 98 +++++++++
 tb/tb_pma_scan_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - core configuration record and PMA range-check helpers
package config_pkg;

  typedef struct packed {
    int unsigned       NrNonIdempotentRules;
    logic [15:0][63:0] NonIdempotentAddrBase;
    logic [15:0][63:0] NonIdempotentLength;
    int unsigned       NrExecuteRegionRules;
    logic [15:0][63:0] ExecuteRegionAddrBase;
    logic [15:0][63:0] ExecuteRegionLength;
    int unsigned       NrCachedRegionRules;
    logic [15:0][63:0] CachedRegionAddrBase;
    logic [15:0][63:0] CachedRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '0;

  typedef struct packed {
    logic nonidem;
    logic exec;
    logic cache;
  } pma_attr_t;

  // The 65-bit sum keeps regions that end at 2^64 from wrapping; len = 0 never matches.
  function automatic logic range_check(logic [63:0] base, logic [63:0] len, logic [63:0] address);
    return (address >= base) && ({1'b0, address} < (65'(base) + 65'(len)));
  endfunction

  function automatic pma_attr_t range_check_slice(cva6_cfg_t Cfg, logic [63:0] addr,
                                                  logic [4:0] start, int unsigned rpc);
    pma_attr_t   hit;
    int unsigned k;
    hit = '0;
    for (int unsigned j = 0; j < 16; j++) begin
      k = 32'(start) + j;
      if (j < rpc && k < 16) begin
        if (k < Cfg.NrNonIdempotentRules)
          hit.nonidem = hit.nonidem | range_check(Cfg.NonIdempotentAddrBase[k[3:0]],
                                                  Cfg.NonIdempotentLength[k[3:0]], addr);
        if (k < Cfg.NrExecuteRegionRules)
          hit.exec = hit.exec | range_check(Cfg.ExecuteRegionAddrBase[k[3:0]],
                                            Cfg.ExecuteRegionLength[k[3:0]], addr);
        if (k < Cfg.NrCachedRegionRules)
          hit.cache = hit.cache | range_check(Cfg.CachedRegionAddrBase[k[3:0]],
                                              Cfg.CachedRegionLength[k[3:0]], addr);
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/pma_scan_ctrl_pkg.sv
// rtl/pma_scan_ctrl_pkg.sv - FSM encoding and sizing helpers for the PMA scan controller
package pma_scan_ctrl_pkg;

  localparam int unsigned IdxWidth = 5;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } scanState_e;

  function automatic int unsigned maxRules(config_pkg::cva6_cfg_t cfg);
    int unsigned m;
    m = cfg.NrNonIdempotentRules;
    if (cfg.NrExecuteRegionRules > m) m = cfg.NrExecuteRegionRules;
    if (cfg.NrCachedRegionRules > m) m = cfg.NrCachedRegionRules;
    return m;
  endfunction

endpackage

// File: rtl/pma_scan_slice.sv
// rtl/pma_scan_slice.sv - combinational evaluator for one window of PMA rules in all three tables
module pma_scan_slice
  import config_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
  parameter int unsigned RulesPerCycle = 4
) (
  input  logic [63:0] addr,
  input  logic [4:0]  start,
  output pma_attr_t   hit
);

  assign hit = range_check_slice(CVA6Cfg, addr, start, RulesPerCycle);

endmodule

// File: rtl/pma_scan_ctrl.sv
// rtl/pma_scan_ctrl.sv - iterative PMA lookup: walks the rule tables a window per cycle
module pma_scan_ctrl
  import config_pkg::*;
  import pma_scan_ctrl_pkg::*;
#(
  parameter cva6_cfg_t   CVA6Cfg       = cva6_cfg_empty,
  parameter int unsigned RulesPerCycle = 4,
  parameter int unsigned TagWidth      = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [63:0]         req_addr_i,
  input  logic [TagWidth-1:0] req_tag_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [TagWidth-1:0] rsp_tag_o,
  output logic                rsp_nonidem_o,
  output logic                rsp_exec_o,
  output logic                rsp_cache_o,
  output logic [4:0]          rsp_cycles_o,
  output logic                busy_o
);

  localparam int unsigned MaxRules = maxRules(CVA6Cfg);
  localparam logic [5:0]  Step     = 6'(RulesPerCycle);
  localparam logic [5:0]  Last     = 6'(MaxRules);

  scanState_e          state;
  logic [63:0]         addrQ;
  logic [TagWidth-1:0] tagQ;
  pma_attr_t           flagsQ;
  logic [IdxWidth-1:0] idxQ;
  logic [IdxWidth-1:0] cntQ;
  pma_attr_t           sliceHit;
  pma_attr_t           flagsNext;
  logic                scanDone;

  pma_scan_slice #(
    .CVA6Cfg      (CVA6Cfg),
    .RulesPerCycle(RulesPerCycle)
  ) i_slice (
    .addr (addrQ),
    .start(idxQ),
    .hit  (sliceHit)
  );

  assign flagsNext = pma_attr_t'(flagsQ | sliceHit);
  // Stop once the last window is covered or nothing further can change the answer.
  assign scanDone  = (({1'b0, idxQ} + Step) >= Last) ||
                     (flagsNext.nonidem && flagsNext.exec && flagsNext.cache);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      addrQ  <= '0;
      tagQ   <= '0;
      flagsQ <= '0;
      idxQ   <= '0;
      cntQ   <= '0;
    end else if (flush_i) begin
      state  <= IDLE;
      flagsQ <= '0;
      cntQ   <= '0;
    end else begin
      unique case (state)
        IDLE: if (req_valid_i) begin
          addrQ  <= req_addr_i;
          tagQ   <= req_tag_i;
          flagsQ <= '0;
          idxQ   <= '0;
          cntQ   <= '0;
          state  <= SCAN;
        end
        SCAN: begin
          flagsQ <= flagsNext;
          idxQ   <= idxQ + Step[IdxWidth-1:0];
          cntQ   <= cntQ + 5'd1;
          if (scanDone) state <= RESP;
        end
        RESP: if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready_o   = (state == IDLE) && !flush_i;
  assign rsp_valid_o   = (state == RESP);
  assign busy_o        = (state != IDLE);
  assign rsp_tag_o     = tagQ;
  assign rsp_nonidem_o = flagsQ.nonidem;
  assign rsp_exec_o    = flagsQ.exec;
  assign rsp_cache_o   = flagsQ.cache;
  assign rsp_cycles_o  = cntQ;

endmodule

// File: tb/tb_pma_scan_ctrl.sv
// tb/tb_pma_scan_ctrl.sv - scoreboard bench for pma_scan_ctrl across three rule/width configurations
module tb_pma_scan_ctrl;

  function automatic config_pkg::cva6_cfg_t mkCfgA();
    config_pkg::cva6_cfg_t c;
    c = '0;
    c.NrCachedRegionRules      = 1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    c.NrNonIdempotentRules     = 1;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'h8000_0000;
    c.NrExecuteRegionRules     = 3;
    c.ExecuteRegionAddrBase[0] = 64'h0;
    c.ExecuteRegionLength[0]   = 64'h1000;
    c.ExecuteRegionAddrBase[1] = 64'h1_0000;
    c.ExecuteRegionLength[1]   = 64'h1_0000;
    c.ExecuteRegionAddrBase[2] = 64'h8000_0000;
    c.ExecuteRegionLength[2]   = 64'h4000_0000;
    return c;
  endfunction

  function automatic config_pkg::cva6_cfg_t mkCfgC();
    config_pkg::cva6_cfg_t c;
    c = '0;
    c.NrNonIdempotentRules     = 1;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'h1_0000_0000;
    c.NrCachedRegionRules      = 1;
    c.CachedRegionAddrBase[0]  = 64'h0;
    c.CachedRegionLength[0]    = 64'h1_0000_0000;
    c.NrExecuteRegionRules     = 16;
    c.ExecuteRegionAddrBase[0] = 64'h0;
    c.ExecuteRegionLength[0]   = 64'h1_0000_0000;
    for (int i = 1; i < 16; i++) begin
      c.ExecuteRegionAddrBase[i] = 64'h10_0000_0000 + 64'(i) * 64'h1000;
      c.ExecuteRegionLength[i]   = 64'h1000;
    end
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t CfgA = mkCfgA();
  localparam config_pkg::cva6_cfg_t CfgC = mkCfgC();

  typedef struct {
    string      name;
    logic [3:0] tag;
    logic [2:0] flags;
    logic [4:0] cycles;
    int         lat;
  } exp_t;

  logic        clk;
  logic        rstN;
  logic        flush;
  logic        rspReady;
  logic [63:0] reqAddr;
  logic [3:0]  reqTag;
  logic        reqValid   [3];
  logic        reqReady   [3];
  logic        rspValid   [3];
  logic [3:0]  rspTag     [3];
  logic        rspNonidem [3];
  logic        rspExec    [3];
  logic        rspCache   [3];
  logic [4:0]  rspCycles  [3];
  logic        busy       [3];

  exp_t sb[$];
  int   nCompared   = 0;
  int   nMismatched = 0;
  int   cyc         = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pma_scan_ctrl #(.CVA6Cfg(CfgA), .RulesPerCycle(4), .TagWidth(4)) dutA (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush),
    .req_valid_i(reqValid[0]), .req_ready_o(reqReady[0]), .req_addr_i(reqAddr), .req_tag_i(reqTag),
    .rsp_valid_o(rspValid[0]), .rsp_ready_i(rspReady), .rsp_tag_o(rspTag[0]),
    .rsp_nonidem_o(rspNonidem[0]), .rsp_exec_o(rspExec[0]), .rsp_cache_o(rspCache[0]),
    .rsp_cycles_o(rspCycles[0]), .busy_o(busy[0]));

  pma_scan_ctrl #(.CVA6Cfg(CfgA), .RulesPerCycle(1), .TagWidth(4)) dutB (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush),
    .req_valid_i(reqValid[1]), .req_ready_o(reqReady[1]), .req_addr_i(reqAddr), .req_tag_i(reqTag),
    .rsp_valid_o(rspValid[1]), .rsp_ready_i(rspReady), .rsp_tag_o(rspTag[1]),
    .rsp_nonidem_o(rspNonidem[1]), .rsp_exec_o(rspExec[1]), .rsp_cache_o(rspCache[1]),
    .rsp_cycles_o(rspCycles[1]), .busy_o(busy[1]));

  pma_scan_ctrl #(.CVA6Cfg(CfgC), .RulesPerCycle(1), .TagWidth(4)) dutC (
    .clk_i(clk), .rst_ni(rstN), .flush_i(flush),
    .req_valid_i(reqValid[2]), .req_ready_o(reqReady[2]), .req_addr_i(reqAddr), .req_tag_i(reqTag),
    .rsp_valid_o(rspValid[2]), .rsp_ready_i(rspReady), .rsp_tag_o(rspTag[2]),
    .rsp_nonidem_o(rspNonidem[2]), .rsp_exec_o(rspExec[2]), .rsp_cache_o(rspCache[2]),
    .rsp_cycles_o(rspCycles[2]), .busy_o(busy[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mkExp(string n, logic [3:0] t, logic [2:0] f, logic [4:0] c, int l);
    exp_t e;
    e.name = n; e.tag = t; e.flags = f; e.cycles = c; e.lat = l;
    return e;
  endfunction

  // Holds the request until accepted, then scrambles the address bus to prove it was latched.
  task automatic send(input int d, input logic [63:0] a, input logic [3:0] t);
    int n;
    n = 0;
    reqAddr = a; reqTag = t; reqValid[d] = 1'b1;
    while (!reqReady[d] && n < 50) begin tick(); n++; end
    tick();
    reqValid[d] = 1'b0;
    reqAddr = 64'hFFFF_FFFF_FFFF_0000;
  endtask

  task automatic waitRsp(input int d, output int lat);
    lat = 0;
    while (!rspValid[d] && lat < 40) begin tick(); lat++; end
  endtask

  task automatic test_reset();
    rstN = 1'b0; flush = 1'b0; rspReady = 1'b1; reqAddr = '0; reqTag = '0;
    for (int d = 0; d < 3; d++) reqValid[d] = 1'b0;
    repeat (3) tick();
    for (int d = 0; d < 3; d++) begin
      nCompared++;
      if ({busy[d], rspValid[d], reqReady[d], rspNonidem[d], rspExec[d], rspCache[d], rspTag[d], rspCycles[d]}
          !== {1'b0, 1'b0, 1'b1, 3'b000, 4'h0, 5'd0}) begin
        nMismatched++;
        $display("FAIL reset[%0d]: busy=%b valid=%b ready=%b flags=%b%b%b tag=%h cycles=%0d, want ready=1 rest 0",
                 d, busy[d], rspValid[d], reqReady[d], rspNonidem[d], rspExec[d], rspCache[d], rspTag[d], rspCycles[d]);
      end
    end
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [63:0] addrs [4] = '{64'h8000_1000, 64'hBFFF_FFFF, 64'hC000_0000, 64'h0000_0FFF};
    logic [2:0]  flags [4] = '{3'b011, 3'b011, 3'b000, 3'b110};
    exp_t e;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mkExp("basic", 4'(i + 5), flags[i], 5'd1, 1));
      send(0, addrs[i], 4'(i + 5));
      waitRsp(0, lat);
      e = sb.pop_front();
      nCompared++; if (lat !== e.lat) begin nMismatched++; $display("FAIL %s[%0d] latency: got %0d want %0d", e.name, i, lat, e.lat); end
      nCompared++; if ({rspNonidem[0], rspExec[0], rspCache[0]} !== e.flags) begin nMismatched++; $display("FAIL %s[%0d] flags: got %b%b%b want %b", e.name, i, rspNonidem[0], rspExec[0], rspCache[0], e.flags); end
      nCompared++; if (rspTag[0] !== e.tag) begin nMismatched++; $display("FAIL %s[%0d] tag: got %h want %h", e.name, i, rspTag[0], e.tag); end
      nCompared++; if (rspCycles[0] !== e.cycles) begin nMismatched++; $display("FAIL %s[%0d] cycles: got %0d want %0d", e.name, i, rspCycles[0], e.cycles); end
      tick();
    end
  endtask

  task automatic test_serial();
    logic [63:0] addrs [3] = '{64'h1_0800, 64'h8000_0000, 64'hC000_0000};
    logic [2:0]  flags [3] = '{3'b110, 3'b011, 3'b000};
    exp_t e;
    int   lat;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mkExp("serial", 4'(i + 1), flags[i], 5'd3, 3));
      send(1, addrs[i], 4'(i + 1));
      waitRsp(1, lat);
      e = sb.pop_front();
      nCompared++; if (lat !== e.lat) begin nMismatched++; $display("FAIL %s[%0d] latency: got %0d want %0d", e.name, i, lat, e.lat); end
      nCompared++; if ({rspNonidem[1], rspExec[1], rspCache[1]} !== e.flags) begin nMismatched++; $display("FAIL %s[%0d] flags: got %b%b%b want %b", e.name, i, rspNonidem[1], rspExec[1], rspCache[1], e.flags); end
      nCompared++; if (rspTag[1] !== e.tag) begin nMismatched++; $display("FAIL %s[%0d] tag: got %h want %h", e.name, i, rspTag[1], e.tag); end
      nCompared++; if (rspCycles[1] !== e.cycles) begin nMismatched++; $display("FAIL %s[%0d] cycles: got %0d want %0d", e.name, i, rspCycles[1], e.cycles); end
      tick();
    end
  endtask

  task automatic test_early_term();
    logic [63:0] addrs [5] = '{64'h100, 64'hFFFF_FFFF, 64'h1_0000_0000, 64'h10_0000_F800, 64'h10_0000_1000};
    logic [2:0]  flags [5] = '{3'b111, 3'b111, 3'b000, 3'b010, 3'b010};
    logic [4:0]  cycs  [5] = '{5'd1, 5'd1, 5'd16, 5'd16, 5'd16};
    exp_t e;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(mkExp("early", 4'(i + 1), flags[i], cycs[i], int'(cycs[i])));
      send(2, addrs[i], 4'(i + 1));
      waitRsp(2, lat);
      e = sb.pop_front();
      nCompared++; if (lat !== e.lat) begin nMismatched++; $display("FAIL %s[%0d] latency: got %0d want %0d", e.name, i, lat, e.lat); end
      nCompared++; if ({rspNonidem[2], rspExec[2], rspCache[2]} !== e.flags) begin nMismatched++; $display("FAIL %s[%0d] flags: got %b%b%b want %b", e.name, i, rspNonidem[2], rspExec[2], rspCache[2], e.flags); end
      nCompared++; if (rspTag[2] !== e.tag) begin nMismatched++; $display("FAIL %s[%0d] tag: got %h want %h", e.name, i, rspTag[2], e.tag); end
      nCompared++; if (rspCycles[2] !== e.cycles) begin nMismatched++; $display("FAIL %s[%0d] cycles: got %0d want %0d", e.name, i, rspCycles[2], e.cycles); end
      tick();
    end
  endtask

  task automatic test_flush();
    exp_t e;
    int   lat;
    bit   sawValid;
    send(1, 64'h1_0800, 4'h3);
    tick();
    flush = 1'b1; reqValid[0] = 1'b1; reqValid[1] = 1'b1; reqAddr = 64'h8000_1000; reqTag = 4'hE;
    #1;
    nCompared++; if (reqReady[1] !== 1'b0) begin nMismatched++; $display("FAIL flush ready_scan: got %b want 0", reqReady[1]); end
    nCompared++; if (reqReady[0] !== 1'b0) begin nMismatched++; $display("FAIL flush ready_idle: got %b want 0", reqReady[0]); end
    tick();
    nCompared++; if ({busy[1], rspValid[1]} !== 2'b00) begin nMismatched++; $display("FAIL flush abort: busy=%b valid=%b want 00", busy[1], rspValid[1]); end
    nCompared++; if (busy[0] !== 1'b0) begin nMismatched++; $display("FAIL flush no_accept: busy=%b want 0", busy[0]); end
    flush = 1'b0; reqValid[0] = 1'b0; reqValid[1] = 1'b0;
    #1;
    nCompared++; if (reqReady[1] !== 1'b1) begin nMismatched++; $display("FAIL flush ready_after: got %b want 1", reqReady[1]); end
    sawValid = 1'b0;
    repeat (6) begin tick(); sawValid |= rspValid[1]; end
    nCompared++; if (sawValid !== 1'b0) begin nMismatched++; $display("FAIL flush stray_rsp: got %b want 0", sawValid); end
    sb.push_back(mkExp("post_flush", 4'h6, 3'b011, 5'd3, 3));
    send(1, 64'h8000_1000, 4'h6);
    waitRsp(1, lat);
    e = sb.pop_front();
    nCompared++; if (lat !== e.lat) begin nMismatched++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
    nCompared++; if ({rspNonidem[1], rspExec[1], rspCache[1]} !== e.flags) begin nMismatched++; $display("FAIL %s flags: got %b%b%b want %b", e.name, rspNonidem[1], rspExec[1], rspCache[1], e.flags); end
    nCompared++; if (rspTag[1] !== e.tag) begin nMismatched++; $display("FAIL %s tag: got %h want %h", e.name, rspTag[1], e.tag); end
    nCompared++; if (rspCycles[1] !== e.cycles) begin nMismatched++; $display("FAIL %s cycles: got %0d want %0d", e.name, rspCycles[1], e.cycles); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [5] = '{64'h0FFF, 64'h1000, 64'h1_FFFF, 64'h2_0000, 64'h8000_0000};
    logic [2:0]  flags [5] = '{3'b110, 3'b100, 3'b110, 3'b100, 3'b011};
    int   acc [5];
    int   n;
    int   lat;
    exp_t e;
    reqValid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reqAddr = addrs[i]; reqTag = 4'(i + 8);
      n = 0;
      while (!reqReady[0] && n < 20) begin tick(); n++; end
      acc[i] = cyc;
      sb.push_back(mkExp("b2b", 4'(i + 8), flags[i], 5'd1, 1));
      tick();
      reqAddr = 64'hFFFF_FFFF_FFFF_0000;
      waitRsp(0, lat);
      e = sb.pop_front();
      nCompared++; if (lat !== e.lat) begin nMismatched++; $display("FAIL %s[%0d] latency: got %0d want %0d", e.name, i, lat, e.lat); end
      nCompared++; if ({rspNonidem[0], rspExec[0], rspCache[0]} !== e.flags) begin nMismatched++; $display("FAIL %s[%0d] flags: got %b%b%b want %b", e.name, i, rspNonidem[0], rspExec[0], rspCache[0], e.flags); end
      nCompared++; if (rspTag[0] !== e.tag) begin nMismatched++; $display("FAIL %s[%0d] tag: got %h want %h", e.name, i, rspTag[0], e.tag); end
      if (i > 0) begin
        nCompared++; if (acc[i] - acc[i-1] !== 3) begin nMismatched++; $display("FAIL %s[%0d] interval: got %0d want 3", e.name, i, acc[i] - acc[i-1]); end
      end
      tick();
    end
    reqValid[0] = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    exp_t e;
    int   lat;
    rspReady = 1'b0;
    sb.push_back(mkExp("stall", 4'h9, 3'b011, 5'd1, 1));
    send(0, 64'h8000_1000, 4'h9);
    waitRsp(0, lat);
    e = sb.pop_front();
    nCompared++; if (lat !== e.lat) begin nMismatched++; $display("FAIL %s latency: got %0d want %0d", e.name, lat, e.lat); end
    nCompared++; if ({rspNonidem[0], rspExec[0], rspCache[0]} !== e.flags) begin nMismatched++; $display("FAIL %s flags: got %b%b%b want %b", e.name, rspNonidem[0], rspExec[0], rspCache[0], e.flags); end
    for (int i = 0; i < 10; i++) begin
      tick();
      nCompared++;
      if ({rspValid[0], reqReady[0], rspNonidem[0], rspExec[0], rspCache[0], rspTag[0], rspCycles[0]}
          !== {1'b1, 1'b0, 3'b011, 4'h9, 5'd1}) begin
        nMismatched++;
        $display("FAIL stall hold[%0d]: valid=%b ready=%b flags=%b%b%b tag=%h cycles=%0d want 1 0 011 9 1",
                 i, rspValid[0], reqReady[0], rspNonidem[0], rspExec[0], rspCache[0], rspTag[0], rspCycles[0]);
      end
    end
    rspReady = 1'b1;
    tick();
    nCompared++; if ({rspValid[0], reqReady[0], busy[0]} !== 3'b010) begin nMismatched++; $display("FAIL stall release: valid=%b ready=%b busy=%b want 010", rspValid[0], reqReady[0], busy[0]); end
  endtask

  task automatic test_reset_midscan();
    bit sawValid;
    send(1, 64'h1_0800, 4'h7);
    nCompared++; if (busy[1] !== 1'b1) begin nMismatched++; $display("FAIL midscan busy_before: got %b want 1", busy[1]); end
    #2 rstN = 1'b0;
    #1;
    nCompared++; if ({rspValid[1], busy[1], reqReady[1]} !== 3'b001) begin nMismatched++; $display("FAIL midscan reset: valid=%b busy=%b ready=%b want 001", rspValid[1], busy[1], reqReady[1]); end
    tick();
    rstN = 1'b1;
    sawValid = 1'b0;
    repeat (8) begin tick(); sawValid |= rspValid[1]; end
    nCompared++; if (sawValid !== 1'b0) begin nMismatched++; $display("FAIL midscan stray_rsp: got %b want 0", sawValid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_serial();
    test_early_term();
    test_flush();
    test_back_to_back();
    test_stall();
    test_reset_midscan();
    nCompared++;
    if (sb.size() !== 0) begin nMismatched++; $display("FAIL scoreboard drain: %0d left want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
